// File: rtl/pipeline_control_unit_pkg.sv
// Shared types and defaults for the pipeline control unit and its helpers.
// Holds the FSM state encoding and the packed enable/flush bundles.
package pipeline_control_unit_pkg;

  localparam int unsigned DEF_NB_COUNTER  = 32;
  localparam int unsigned DEF_MEM_TIMEOUT = 16;
  localparam int unsigned NB_OPERAND      = 32;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  // Load enables for the PC and the four pipeline registers.
  typedef struct packed {
    logic pc;
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
  } stage_en_t;

  // Bubble-insertion requests for the front-end pipeline registers.
  typedef struct packed {
    logic if_id;
    logic id_ex;
  } stage_flush_t;

endpackage

// File: rtl/pipeline_control_unit_sat_counter.sv
// Saturating up-counter with enable and synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (en && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_control_unit.sv
// Stall/flush/halt controller for a five-stage pipeline with a data-memory
// timeout watchdog and saturating performance counters.
module pipeline_control_unit
  import pipeline_control_unit_pkg::*;
#(
  parameter int unsigned NB_COUNTER  = DEF_NB_COUNTER,
  parameter int unsigned MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_load_hazard,
  input  logic                  i_branch_hazard,
  input  logic                  i_imem_ready,
  input  logic                  i_dmem_req,
  input  logic                  i_dmem_ready,
  input  logic                  i_halt,
  output logic                  o_pc_en,
  output logic                  o_if_id_en,
  output logic                  o_id_ex_en,
  output logic                  o_ex_mem_en,
  output logic                  o_mem_wb_en,
  output logic                  o_if_id_flush,
  output logic                  o_id_ex_flush,
  output logic                  o_halted,
  output logic                  o_bus_error,
  output logic [NB_COUNTER-1:0] o_cycle_count,
  output logic [NB_COUNTER-1:0] o_stall_count,
  output logic [NB_COUNTER-1:0] o_flush_count
);

  localparam int unsigned NB_TMO = $clog2(MEM_TIMEOUT + 1);

  state_t            state_q;
  state_t            state_next;
  logic [NB_TMO-1:0] tmo_q;
  logic              bus_error_q;
  logic              dmem_stall;
  logic              timeout_hit;
  logic              branch_flush;
  logic              active;
  stage_en_t         en;
  stage_flush_t      flush;

  // A memory stall only matters while the core is still executing.
  assign dmem_stall  = i_dmem_req && !i_dmem_ready && (state_q != HALT);
  assign timeout_hit = dmem_stall && (tmo_q == NB_TMO'(MEM_TIMEOUT - 1));
  assign active      = !i_reset && (state_q != HALT);

  // State register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_next;
    end
  end

  // Next-state logic; HALT is left only through reset.
  always_comb begin
    state_next = state_q;
    case (state_q)
      RUN, MEM_WAIT: begin
        if (dmem_stall) begin
          state_next = timeout_hit ? HALT : MEM_WAIT;
        end else if (i_halt) begin
          state_next = HALT;
        end else begin
          state_next = RUN;
        end
      end
      HALT:    state_next = HALT;
      default: state_next = RUN;
    endcase
  end

  // Enable/flush decode in priority order: halt state, memory stall,
  // halt request, branch, load-use, fetch wait, normal flow.
  always_comb begin
    en           = '1;
    flush        = '0;
    branch_flush = 1'b0;
    if (i_reset) begin
      en    = '0;
      flush = '1;
    end else begin
      case (state_q)
        HALT: en = '0;
        default: begin
          if (dmem_stall) begin
            en = '0;
          end else if (i_halt) begin
            en = '1;
          end else if (i_branch_hazard) begin
            flush.if_id  = 1'b1;
            flush.id_ex  = 1'b1;
            branch_flush = 1'b1;
          end else if (i_load_hazard) begin
            en.pc       = 1'b0;
            en.if_id    = 1'b0;
            flush.id_ex = 1'b1;
          end else if (!i_imem_ready) begin
            en.pc       = 1'b0;
            flush.if_id = 1'b1;
          end
        end
      endcase
    end
  end

  // Consecutive memory-stall counter; restarts from RUN and on any progress.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      tmo_q <= '0;
    end else if (dmem_stall) begin
      tmo_q <= (state_q == RUN) ? NB_TMO'(1) : tmo_q + NB_TMO'(1);
    end else begin
      tmo_q <= '0;
    end
  end

  // Sticky bus-error flag.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      bus_error_q <= 1'b0;
    end else if (timeout_hit) begin
      bus_error_q <= 1'b1;
    end
  end

  assign o_pc_en       = en.pc;
  assign o_if_id_en    = en.if_id;
  assign o_id_ex_en    = en.id_ex;
  assign o_ex_mem_en   = en.ex_mem;
  assign o_mem_wb_en   = en.mem_wb;
  assign o_if_id_flush = flush.if_id;
  assign o_id_ex_flush = flush.id_ex;
  assign o_halted      = !i_reset && (state_q == HALT);
  assign o_bus_error   = !i_reset && bus_error_q;

  sat_counter #(.WIDTH(NB_COUNTER)) u_cycle_count (
    .clk   (i_clock),
    .clr   (i_reset),
    .en    (active),
    .count (o_cycle_count)
  );

  sat_counter #(.WIDTH(NB_COUNTER)) u_stall_count (
    .clk   (i_clock),
    .clr   (i_reset),
    .en    (active && !en.pc),
    .count (o_stall_count)
  );

  sat_counter #(.WIDTH(NB_COUNTER)) u_flush_count (
    .clk   (i_clock),
    .clr   (i_reset),
    .en    (branch_flush),
    .count (o_flush_count)
  );

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Directed bench for pipeline_control_unit with small counters (saturate at 31)
// and a short memory timeout (4 cycles).
module tb_pipeline_control_unit;

  localparam int unsigned NB  = 5;
  localparam int unsigned TMO = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          ld    = 1'b0;
  logic          br    = 1'b0;
  logic          imem  = 1'b1;
  logic          dreq  = 1'b0;
  logic          drdy  = 1'b0;
  logic          halt  = 1'b0;
  logic          pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic          if_id_flush, id_ex_flush, halted, bus_error;
  logic [NB-1:0] cycle_count, stall_count, flush_count;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pipeline_control_unit #(.NB_COUNTER(NB), .MEM_TIMEOUT(TMO)) dut (
    .i_clock        (clock),
    .i_reset        (reset),
    .i_load_hazard  (ld),
    .i_branch_hazard(br),
    .i_imem_ready   (imem),
    .i_dmem_req     (dreq),
    .i_dmem_ready   (drdy),
    .i_halt         (halt),
    .o_pc_en        (pc_en),
    .o_if_id_en     (if_id_en),
    .o_id_ex_en     (id_ex_en),
    .o_ex_mem_en    (ex_mem_en),
    .o_mem_wb_en    (mem_wb_en),
    .o_if_id_flush  (if_id_flush),
    .o_id_ex_flush  (id_ex_flush),
    .o_halted       (halted),
    .o_bus_error    (bus_error),
    .o_cycle_count  (cycle_count),
    .o_stall_count  (stall_count),
    .o_flush_count  (flush_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Enables packed {pc, if_id, id_ex, ex_mem, mem_wb}; flushes {if_id, id_ex}.
  task automatic chk_ctl(input string tag, input logic [4:0] en_exp, input logic [1:0] fl_exp);
    chk({tag, "_en"}, 32'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}), 32'(en_exp));
    chk({tag, "_fl"}, 32'({if_id_flush, id_ex_flush}), 32'(fl_exp));
  endtask

  task automatic chk_cnt(input string tag, input int cyc, input int stl, input int fls);
    chk({tag, "_cycle"}, 32'(cycle_count), 32'(cyc));
    chk({tag, "_stall"}, 32'(stall_count), 32'(stl));
    chk({tag, "_flush"}, 32'(flush_count), 32'(fls));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic quiet();
    ld = 1'b0; br = 1'b0; imem = 1'b1; dreq = 1'b0; drdy = 1'b0; halt = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    // Reset outputs while reset is held, then state after the first edge
    #1;
    chk_ctl("rst_hold", 5'b00000, 2'b11);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_buserr", 32'(bus_error), 32'd0);
    tick();
    chk_cnt("rst_cnt", 0, 0, 0);
    reset = 1'b0;
    #1;

    // Idle flow
    chk_ctl("idle", 5'b11111, 2'b00);
    repeat (10) tick();
    chk_cnt("idle10", 10, 0, 0);
    chk_ctl("idle10", 5'b11111, 2'b00);

    // One-cycle load-use stall
    ld = 1'b1;
    #1;
    chk_ctl("load", 5'b00111, 2'b01);
    tick();
    ld = 1'b0;
    #1;
    chk_ctl("load_after", 5'b11111, 2'b00);
    chk_cnt("load_cnt", 11, 1, 0);

    // Branch beats load
    do_reset();
    br = 1'b1; ld = 1'b1;
    #1;
    chk_ctl("br_ld", 5'b11111, 2'b11);
    tick();
    quiet();
    chk_cnt("br_ld_cnt", 1, 0, 1);

    // Memory stall freezes a pending branch for 3 cycles
    do_reset();
    dreq = 1'b1; drdy = 1'b0; br = 1'b1;
    #1;
    chk_ctl("mw_first", 5'b00000, 2'b00);
    tick();
    tick();
    chk_ctl("mw_third", 5'b00000, 2'b00);
    tick();
    drdy = 1'b1;
    #1;
    chk_ctl("mw_ready", 5'b11111, 2'b11);
    tick();
    quiet();
    chk_cnt("mw_cnt", 4, 3, 1);
    chk("mw_buserr", 32'(bus_error), 32'd0);

    // Timeout after 4 stall cycles
    do_reset();
    dreq = 1'b1; drdy = 1'b0;
    repeat (3) tick();
    chk("tmo3_buserr", 32'(bus_error), 32'd0);
    chk("tmo3_halted", 32'(halted), 32'd0);
    tick();
    chk("tmo4_buserr", 32'(bus_error), 32'd1);
    chk("tmo4_halted", 32'(halted), 32'd1);
    chk_cnt("tmo4_cnt", 4, 4, 0);
    drdy = 1'b1; br = 1'b1;
    repeat (3) tick();
    chk_ctl("tmo_halt", 5'b00000, 2'b00);
    chk_cnt("tmo_frozen", 4, 4, 0);
    chk("tmo_sticky", 32'(bus_error), 32'd1);
    quiet();

    // Halt request, then reset out of HALT
    do_reset();
    chk("halt_rst_buserr", 32'(bus_error), 32'd0);
    halt = 1'b1;
    #1;
    chk_ctl("halt_req", 5'b11111, 2'b00);
    tick();
    halt = 1'b0;
    #1;
    chk("halt_halted", 32'(halted), 32'd1);
    chk_ctl("halt_state", 5'b00000, 2'b00);
    tick();
    chk_cnt("halt_cnt", 1, 0, 0);
    reset = 1'b1;
    #1;
    chk_ctl("halt_rsthold", 5'b00000, 2'b11);
    chk("halt_rsthold_halted", 32'(halted), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("halt_out_halted", 32'(halted), 32'd0);
    chk("halt_out_buserr", 32'(bus_error), 32'd0);
    chk_cnt("halt_out_cnt", 0, 0, 0);
    chk_ctl("halt_out", 5'b11111, 2'b00);

    // Fetch wait, and branch during fetch wait
    imem = 1'b0;
    #1;
    chk_ctl("fetch", 5'b01111, 2'b10);
    tick();
    chk_cnt("fetch_cnt", 1, 1, 0);
    br = 1'b1;
    #1;
    chk_ctl("fetch_br", 5'b11111, 2'b11);
    tick();
    quiet();
    chk_cnt("fetch_br_cnt", 2, 1, 1);

    // Counter saturation
    do_reset();
    ld = 1'b1;
    repeat (40) tick();
    chk_cnt("sat", 31, 31, 0);
    quiet();

    // Reset mid MEM_WAIT clears the timeout counter
    do_reset();
    dreq = 1'b1; drdy = 1'b0;
    repeat (2) tick();
    do_reset();
    repeat (3) tick();
    chk("mwrst_buserr3", 32'(bus_error), 32'd0);
    chk_cnt("mwrst_cnt", 3, 3, 0);
    tick();
    chk("mwrst_buserr4", 32'(bus_error), 32'd1);
    quiet();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_control_unit.md
PIPELINE_CONTROL_UNIT -- requirements
Module: pipeline_control_unit

Interface
REQ-001 Parameter NB_COUNTER, default 32, width of each performance counter.
REQ-002 Parameter MEM_TIMEOUT, default 16, maximum consecutive data-memory wait cycles before a bus error.
REQ-003 i_clock  input  1  single clock; all state updates on its rising edge.
REQ-004 i_reset  input  1  synchronous, active-high reset.
REQ-005 i_load_hazard  input  1  load-use hazard detected (EX is a load; its rd matches an ID source register).
REQ-006 i_branch_hazard  input  1  taken branch or jump resolved in EX.
REQ-007 i_imem_ready  input  1  instruction fetch data valid this cycle.
REQ-008 i_dmem_req  input  1  MEM stage holds a load or store.
REQ-009 i_dmem_ready  input  1  data memory completes the access this cycle.
REQ-010 i_halt  input  1  ECALL/EBREAK retiring in WB.
REQ-011 o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en  output  1 each  PC and pipeline-register load enables.
REQ-012 o_if_id_flush, o_id_ex_flush  output  1 each  replace the register contents with a NOP bubble.
REQ-013 o_halted  output  1  core halted.
REQ-014 o_bus_error  output  1  data-memory timeout; sticky.
REQ-015 o_cycle_count, o_stall_count, o_flush_count  output  NB_COUNTER each  performance counters.

Function
REQ-016 The FSM shall have states RUN, MEM_WAIT and HALT, encoded in a shared enum.
REQ-017 Enables and flushes shall be combinational from the state and the current inputs; the state, the timeout counter and the performance counters shall be registered.
REQ-018 Per-cycle priority shall be: HALT, then data-memory stall, then branch flush, then load stall, then fetch wait, then normal flow.
REQ-019 Normal flow shall be: all enables 1, all flushes 0.
REQ-020 Data-memory stall shall apply when i_dmem_req=1 and i_dmem_ready=0 in RUN or MEM_WAIT:
- all enables 0, all flushes 0;
- branch, load and fetch inputs ignored that cycle;
- next state MEM_WAIT.
REQ-021 In MEM_WAIT, i_dmem_ready=1 shall resume normal evaluation in that same cycle, with next state RUN.
REQ-022 A timeout counter shall count consecutive stall cycles and clear whenever the state is RUN.
- When it reaches MEM_TIMEOUT: set o_bus_error, next state HALT.
REQ-023 Branch flush (RUN, i_branch_hazard=1, no memory stall) shall drive o_pc_en=1 and all register enables 1, assert o_if_id_flush=1 and o_id_ex_flush=1, and increment o_flush_count.
REQ-024 Load stall (i_load_hazard=1, no branch) shall drive o_pc_en=0, o_if_id_en=0 and o_id_ex_flush=1, with the remaining enables 1.
- The load stall shall repeat each cycle the hazard stays asserted.
REQ-025 Fetch wait (i_imem_ready=0, no higher-priority event) shall drive o_pc_en=0 and o_if_id_flush=1, with the remaining enables 1.
REQ-026 A branch flush during fetch wait shall still assert o_pc_en=1 so that the target is captured.
REQ-027 i_halt=1 in RUN with no memory stall shall move the state to HALT, and all enables in that cycle shall be 1.
REQ-028 In HALT, all enables shall be 0, all flushes 0 and o_halted=1, and the block shall exit only via reset.
REQ-029 o_cycle_count shall increment every cycle outside HALT.
REQ-030 o_stall_count shall increment every cycle outside HALT with o_pc_en=0.
REQ-031 All counters shall saturate at 2^NB_COUNTER-1 and shall not wrap.

Reset
REQ-032 While i_reset=1, all enables shall be 0, both flushes 1, o_halted 0 and o_bus_error 0.
REQ-033 After the first clock edge with i_reset=1, the state shall be RUN and all counters, including the timeout counter, 0.
REQ-034 Reset shall take precedence from any state, including MEM_WAIT and HALT, mid-operation.

Structure
REQ-035 A shared package shall hold the state enum, the default NB_COUNTER and MEM_TIMEOUT values, and NB_OPERAND.
REQ-036 One sub-module, sat_counter (parameterised width, enable, synchronous clear), shall be instantiated three times for the performance counters.

Verification
REQ-037 Reset then 10 idle cycles with all inputs quiet and i_imem_ready=1 -> o_cycle_count=10, o_stall_count=0, all enables 1.
REQ-038 i_load_hazard=1 for 1 cycle -> o_pc_en=0, o_if_id_en=0, o_id_ex_flush=1 that cycle only; o_stall_count=1.
REQ-039 i_branch_hazard=1 together with i_load_hazard=1 -> both flushes 1, o_pc_en=1; o_flush_count=1, o_stall_count=0.
REQ-040 i_dmem_req=1, i_dmem_ready low for 3 cycles while i_branch_hazard=1 -> 3 frozen cycles with no flush; on ready the branch flush occurs; o_stall_count=3.
REQ-041 i_dmem_ready held low with MEM_TIMEOUT=4 -> o_bus_error=1 and o_halted=1 after 4 stall cycles; o_cycle_count frozen thereafter.
REQ-042 i_halt=1, then i_reset=1 for 1 cycle -> state RUN, counters 0, o_halted=0, o_bus_error=0.
